// File: rtl/ram_bist_ctrl.sv
// Write-then-read march BIST for a single-port RAM: seeded address-XOR pattern, first-fail capture, saturating error count.
// Optional second sweep with the inverted pattern when RAM_BIST_INVERT_PASS_EN is defined.
module ram_bist_ctrl #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            Start,
    input  logic [DW-1:0]   Seed,
    output logic            Busy,
    output logic            Done,
    output logic            Pass,
    output logic [AW+1:0]   ErrCount,
    output logic [AW-1:0]   FailAddr,
    output logic [DW-1:0]   FailData,
    output logic [AW-1:0]   Addr,
    output logic [DW-1:0]   DataIn,
    output logic            RW,
    input  logic [DW-1:0]   DataOut
);

    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   seed_q, seed_d;
    logic            inv_q, inv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [AW+1:0]   err_q, err_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;
    logic [DW-1:0]   fail_data_q, fail_data_d;
    logic [DCW-1:0]  drain_q, drain_d;

    // Compare pipeline: expected data and address travel alongside the RAM read latency
    logic [RD_LAT-1:0] pv_q;
    logic [AW-1:0]     pa_q [RD_LAT];
    logic [DW-1:0]     pe_q [RD_LAT];

    logic [DW-1:0]   pat_cur;
    logic            cmp_vld;
    logic            mismatch;

    function automatic logic [DW-1:0] pattern(input logic [DW-1:0] s,
                                              input logic [AW-1:0] a,
                                              input logic          inv);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i] = s[i] ^ a[i % AW];
        end
        return inv ? ~r : r;
    endfunction

    assign pat_cur  = pattern(seed_q, addr_q, inv_q);
    assign cmp_vld  = pv_q[RD_LAT-1];
    assign mismatch = cmp_vld && (DataOut != pe_q[RD_LAT-1]);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        inv_d       = inv_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        drain_d     = drain_q;

        if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + (AW+2)'(1);
            end
            if (err_q == '0) begin
                fail_addr_d = pa_q[RD_LAT-1];
                fail_data_d = DataOut;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d     = S_WRITE;
                    addr_d      = '0;
                    seed_d      = Seed;
                    inv_d       = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == '1) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == '1) begin
`ifdef RAM_BIST_INVERT_PASS_EN
                    if (!inv_q) begin
                        inv_d   = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
`else
                    state_d = S_DRAIN;
                    drain_d = '0;
`endif
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DCW'(1);
                // The last compare lands on the previous edge, so err_q is final here
                if (drain_q == DCW'(RD_LAT)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            seed_q      <= '0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            inv_q       <= inv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            drain_q     <= drain_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= (state_q == S_READ);
            pa_q[0] <= addr_q;
            pe_q[0] <= pat_cur;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign RW       = (state_q == S_WRITE);
    assign DataIn   = RW ? pat_cur : '0;
    assign Addr     = addr_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Pass     = pass_q;
    assign ErrCount = err_q;
    assign FailAddr = fail_addr_q;
    assign FailData = fail_data_q;

endmodule
